// File: rtl/motion_pkg.sv
// Shared types for the motion command sequencer: command bundle,
// FSM state encoding and axis decode helpers.
package motion_pkg;

   localparam int NUM_AXES = 6;
   localparam int PULSE_W  = 10;
   localparam int AXIS_W   = 3;

   typedef struct packed {
      logic [AXIS_W-1:0]  axis;
      logic               dir;
      logic [PULSE_W-1:0] pulses;
   } cmd_t;

   typedef enum logic [2:0] {
      S_HOME,
      S_HWAIT,
      S_IDLE,
      S_ISSUE,
      S_WAIT_BUSY,
      S_RUN,
      S_PARK
   } state_t;

   // Axis index to one-hot select; out-of-range axes yield zero.
   function automatic logic [NUM_AXES-1:0] axis_onehot(
      input logic [AXIS_W-1:0] a
   );
      logic [NUM_AXES-1:0] m;
      m = '0;
      if (a < AXIS_W'(NUM_AXES))
         m = NUM_AXES'(1) << a;
      return m;
   endfunction

   // A command is dropped when its axis does not exist or it has no steps.
   function automatic logic cmd_bad(input cmd_t c);
      return (c.axis >= AXIS_W'(NUM_AXES)) || (c.pulses == '0);
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO, DEPTH entries of cmd_t, show-ahead read.
// Ports: clk_i, rst_i (sync high), push_i/wdata_i, pop_i/rdata_o, full_o, empty_o.
module cmd_fifo
   import motion_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic push_i,
   input  cmd_t wdata_i,
   input  logic pop_i,
   output cmd_t rdata_o,
   output logic full_o,
   output logic empty_o
);

   localparam int AW = $clog2(DEPTH);

   cmd_t          mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          push_ok;
   logic          pop_ok;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign rdata_o = mem_q[rptr_q];

   // Full blocks pushes even when a pop frees a slot this cycle.
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (push_ok) wptr_d = wptr_q + 1'b1;
      if (pop_ok)  rptr_d = rptr_q + 1'b1;
      unique case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
         if (push_ok)
            mem_q[wptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/motion_cmd_seq.sv
// Command sequencer for the 6-axis step-pulse generator: queues commands,
// homes via INIT, issues one command at a time and parks PulseNum between them.
// Ports: sysclk, RST; cmd_valid/cmd_ready/cmd_axis/cmd_dir/cmd_pulses;
// home_req; Busy, initFlag from generator; INIT, Motor, PulseNum, DRSign to it;
// status homed, cmd_done, err_to, err_cmd.
module motion_cmd_seq
   import motion_pkg::*;
#(
   parameter int DEPTH    = 8,
   parameter int RISE_TO  = 8,
   parameter int PARK_CYC = 4
) (
   input  logic                sysclk,
   input  logic                RST,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [AXIS_W-1:0]   cmd_axis,
   input  logic                cmd_dir,
   input  logic [PULSE_W-1:0]  cmd_pulses,
   input  logic                home_req,
   input  logic                Busy,
   input  logic [NUM_AXES-1:0] initFlag,
   output logic                INIT,
   output logic [NUM_AXES-1:0] Motor,
   output logic [PULSE_W-1:0]  PulseNum,
   output logic [NUM_AXES-1:0] DRSign,
   output logic                homed,
   output logic                cmd_done,
   output logic                err_to,
   output logic                err_cmd
);

   localparam int TMAX = (RISE_TO > PARK_CYC) ? RISE_TO : PARK_CYC;
   localparam int TW   = $clog2(TMAX + 1);

   state_t              state_q, state_d;
   logic                init_q, init_d;
   logic [NUM_AXES-1:0] motor_q, motor_d;
   logic [PULSE_W-1:0]  pulse_q, pulse_d;
   logic [NUM_AXES-1:0] dr_q, dr_d;
   logic                homed_q;
   logic                done_q, done_d;
   logic                err_to_q, err_to_d;
   logic                err_cmd_q, err_cmd_d;
   logic                home_pend_q, home_pend_d;
   logic [TW-1:0]       timer_q, timer_d;

   logic                fifo_full;
   logic                fifo_empty;
   logic                fifo_pop;
   cmd_t                head;
   cmd_t                wcmd;
   logic [NUM_AXES-1:0] head_oh;

   assign wcmd      = '{axis: cmd_axis, dir: cmd_dir, pulses: cmd_pulses};
   assign cmd_ready = ~fifo_full;
   assign head_oh   = axis_onehot(head.axis);

   cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i   (sysclk),
      .rst_i   (RST),
      .push_i  (cmd_valid),
      .wdata_i (wcmd),
      .pop_i   (fifo_pop),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      state_d     = state_q;
      init_d      = 1'b0;
      done_d      = 1'b0;
      motor_d     = motor_q;
      pulse_d     = pulse_q;
      dr_d        = dr_q;
      err_to_d    = err_to_q;
      err_cmd_d   = err_cmd_q;
      home_pend_d = home_pend_q | home_req;
      timer_d     = timer_q;
      fifo_pop    = 1'b0;

      unique case (state_q)
         S_HOME: begin
            init_d      = 1'b1;
            motor_d     = '0;
            pulse_d     = '0;
            home_pend_d = 1'b0;
            state_d     = S_HWAIT;
         end
         S_HWAIT: begin
            // Requests during homing are already satisfied by it.
            home_pend_d = 1'b0;
            if (&initFlag)
               state_d = S_IDLE;
         end
         S_IDLE: begin
            if (home_pend_q) begin
               home_pend_d = 1'b0;
               state_d     = S_HOME;
            end else if (!fifo_empty) begin
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            fifo_pop = 1'b1;
            if (cmd_bad(head)) begin
               err_cmd_d = 1'b1;
               state_d   = S_IDLE;
            end else begin
               motor_d = head_oh;
               pulse_d = head.pulses;
               dr_d    = {NUM_AXES{head.dir}} & head_oh;
               timer_d = '0;
               state_d = S_WAIT_BUSY;
            end
         end
         S_WAIT_BUSY: begin
            if (Busy) begin
               state_d = S_RUN;
            end else if (timer_q == TW'(RISE_TO - 1)) begin
               err_to_d = 1'b1;
               pulse_d  = '0;
               timer_d  = '0;
               state_d  = S_PARK;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_RUN: begin
            if (!Busy) begin
               done_d  = 1'b1;
               pulse_d = '0;
               timer_d = '0;
               state_d = S_PARK;
            end
         end
         S_PARK: begin
            // Zero PulseNum long enough that a repeat command re-triggers Busy.
            pulse_d = '0;
            if (timer_q == TW'(PARK_CYC - 1)) begin
               if (!Busy)
                  state_d = S_IDLE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: state_d = S_HOME;
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (RST) begin
         state_q     <= S_HOME;
         init_q      <= 1'b0;
         motor_q     <= '0;
         pulse_q     <= '0;
         dr_q        <= '0;
         homed_q     <= 1'b0;
         done_q      <= 1'b0;
         err_to_q    <= 1'b0;
         err_cmd_q   <= 1'b0;
         home_pend_q <= 1'b0;
         timer_q     <= '0;
      end else begin
         state_q     <= state_d;
         init_q      <= init_d;
         motor_q     <= motor_d;
         pulse_q     <= pulse_d;
         dr_q        <= dr_d;
         homed_q     <= &initFlag;
         done_q      <= done_d;
         err_to_q    <= err_to_d;
         err_cmd_q   <= err_cmd_d;
         home_pend_q <= home_pend_d;
         timer_q     <= timer_d;
      end
   end

   assign INIT     = init_q;
   assign Motor    = motor_q;
   assign PulseNum = pulse_q;
   assign DRSign   = dr_q;
   assign homed    = homed_q;
   assign cmd_done = done_q;
   assign err_to   = err_to_q;
   assign err_cmd  = err_cmd_q;

endmodule

// File: tb/tb_motion_cmd_seq.sv
// Directed bench for motion_cmd_seq: homing, issue/park, FIFO full and
// drain with timeouts, dropped commands, homing mid-run and reset mid-run.
module tb_motion_cmd_seq;

   logic       sysclk;
   logic       RST;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_axis;
   logic       cmd_dir;
   logic [9:0] cmd_pulses;
   logic       home_req;
   logic       Busy;
   logic [5:0] initFlag;
   logic       INIT;
   logic [5:0] Motor;
   logic [9:0] PulseNum;
   logic [5:0] DRSign;
   logic       homed;
   logic       cmd_done;
   logic       err_to;
   logic       err_cmd;

   int n_assert = 0;
   int n_fail   = 0;
   int done_cnt = 0;

   motion_cmd_seq dut (
      .sysclk     (sysclk),
      .RST        (RST),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_axis   (cmd_axis),
      .cmd_dir    (cmd_dir),
      .cmd_pulses (cmd_pulses),
      .home_req   (home_req),
      .Busy       (Busy),
      .initFlag   (initFlag),
      .INIT       (INIT),
      .Motor      (Motor),
      .PulseNum   (PulseNum),
      .DRSign     (DRSign),
      .homed      (homed),
      .cmd_done   (cmd_done),
      .err_to     (err_to),
      .err_cmd    (err_cmd)
   );

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   always @(posedge sysclk)
      if (cmd_done) done_cnt++;

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge sysclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_pulse(input logic nz);
      for (int i = 0; i < 40; i++) begin
         if ((PulseNum != '0) == nz) break;
         tick();
      end
   endtask

   task automatic wait_done();
      for (int i = 0; i < 10; i++) begin
         if (cmd_done) break;
         tick();
      end
   endtask

   task automatic push(input logic [2:0] a, input logic d,
                       input logic [9:0] p);
      cmd_valid  = 1'b1;
      cmd_axis   = a;
      cmd_dir    = d;
      cmd_pulses = p;
      tick();
      cmd_valid  = 1'b0;
   endtask

   task automatic serve(input logic [9:0] p, input logic [5:0] m,
                        input logic [5:0] d, input int hi);
      wait_pulse(1'b1);
      chk("issue_pulses", PulseNum, p);
      chk("issue_motor", Motor, m);
      chk("issue_dr", DRSign, d);
      Busy = 1'b1;
      repeat (hi) tick();
      Busy = 1'b0;
      wait_done();
      chk("cmd_done", cmd_done, 1);
      chk("park_pulses", PulseNum, 0);
   endtask

   initial begin
      RST        = 1'b1;
      cmd_valid  = 1'b0;
      cmd_axis   = '0;
      cmd_dir    = 1'b0;
      cmd_pulses = '0;
      home_req   = 1'b0;
      Busy       = 1'b0;
      initFlag   = '0;
      tick();
      tick();

      // Reset state
      chk("rst_init", INIT, 0);
      chk("rst_motor", Motor, 0);
      chk("rst_pulses", PulseNum, 0);
      chk("rst_dr", DRSign, 0);
      chk("rst_ready", cmd_ready, 1);
      chk("rst_errs", {err_to, err_cmd, homed, cmd_done}, 0);

      // 1: homing after reset release
      RST = 1'b0;
      tick();
      chk("home_init_hi", INIT, 1);
      tick();
      chk("home_init_lo", INIT, 0);
      initFlag = 6'h3F;
      tick();
      chk("homed", homed, 1);

      // 2: single command, exact two-cycle latency
      push(3'd2, 1'b1, 10'd5);
      tick();
      chk("lat_not_yet", PulseNum, 0);
      tick();
      chk("c2_motor", Motor, 6'b000100);
      chk("c2_dr", DRSign, 6'b000100);
      chk("c2_pulses", PulseNum, 5);
      Busy = 1'b1;
      repeat (3) tick();
      Busy = 1'b0;
      tick();
      chk("c2_done", cmd_done, 1);
      chk("c2_park", PulseNum, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("c2_park_hold", {cmd_done, PulseNum}, 0);
      end
      chk("c2_done_cnt", done_cnt, 1);

      // 3: identical back-to-back commands re-issue
      cmd_valid  = 1'b1;
      cmd_axis   = 3'd0;
      cmd_dir    = 1'b0;
      cmd_pulses = 10'd3;
      tick();
      tick();
      cmd_valid  = 1'b0;
      serve(10'd3, 6'b000001, 6'b000000, 2);
      serve(10'd3, 6'b000001, 6'b000000, 2);
      tick();
      chk("c3_done_cnt", done_cnt, 3);
      chk("c3_no_to", err_to, 0);

      // 4: fill FIFO with Busy stuck low, then drain on timeouts
      repeat (5) tick();
      for (int k = 0; k < 9; k++) begin
         if (k == 8) chk("c4_ready_pre", cmd_ready, 1);
         push(3'(k % 6), k[0], 10'(k + 1));
         cmd_valid = 1'b0;
      end
      chk("c4_full", cmd_ready, 0);
      for (int k = 0; k < 9; k++) begin
         wait_pulse(1'b1);
         chk("c4_order", PulseNum, k + 1);
         wait_pulse(1'b0);
      end
      chk("c4_err_to", err_to, 1);
      chk("c4_ready", cmd_ready, 1);
      repeat (20) tick();
      chk("c4_drained", PulseNum, 0);
      chk("c4_no_done", done_cnt, 3);
      chk("c4_no_errcmd", err_cmd, 0);

      // 5: dropped commands
      push(3'd7, 1'b1, 10'd4);
      push(3'd1, 1'b0, 10'd0);
      repeat (8) tick();
      chk("c5_err_cmd", err_cmd, 1);
      chk("c5_motor", Motor, 6'b000100);
      chk("c5_pulses", PulseNum, 0);
      chk("c5_no_done", done_cnt, 3);

      // 6: home request while running, then reset mid-run
      push(3'd3, 1'b1, 10'd7);
      wait_pulse(1'b1);
      chk("c6_a_pulses", PulseNum, 7);
      chk("c6_a_dr", DRSign, 6'b001000);
      Busy = 1'b1;
      tick();
      home_req   = 1'b1;
      cmd_valid  = 1'b1;
      cmd_axis   = 3'd4;
      cmd_dir    = 1'b0;
      cmd_pulses = 10'd9;
      tick();
      home_req  = 1'b0;
      cmd_valid = 1'b0;
      tick();
      Busy     = 1'b0;
      initFlag = 6'h00;
      wait_done();
      chk("c6_done", cmd_done, 1);
      for (int i = 0; i < 30; i++) begin
         if (INIT || PulseNum != '0) break;
         tick();
      end
      chk("c6_init_first", INIT, 1);
      chk("c6_no_issue", PulseNum, 0);
      chk("c6_home_motor", Motor, 0);
      repeat (5) tick();
      chk("c6_hwait_hold", PulseNum, 0);
      initFlag = 6'h3F;
      wait_pulse(1'b1);
      chk("c6_b_pulses", PulseNum, 9);
      chk("c6_b_motor", Motor, 6'b010000);
      chk("c6_b_dr", DRSign, 0);
      push(3'd5, 1'b1, 10'd11);
      Busy = 1'b1;
      tick();
      tick();
      RST = 1'b1;
      tick();
      chk("c6_rst_motor", Motor, 0);
      chk("c6_rst_pulses", PulseNum, 0);
      chk("c6_rst_dr", DRSign, 0);
      chk("c6_rst_flags", {INIT, homed, cmd_done, err_to, err_cmd}, 0);
      chk("c6_rst_ready", cmd_ready, 1);
      RST  = 1'b0;
      Busy = 1'b0;
      repeat (15) tick();
      chk("c6_fifo_empty", PulseNum, 0);
      chk("c6_rehomed", homed, 1);
      chk("c6_done_total", done_cnt, 4);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
